// File: rtl/cp0_intc.sv
// cp0_intc: CP0 register file (Count/Compare/Status/Cause/EPC/IntMode) with
// synchronised level/edge hardware interrupt lines, timer and exception entry/ERET.
`default_nettype none

module cp0_intc #(
  parameter int NUM_HW_INT  = 6,
  parameter int TIMER_LINE  = 5,
  parameter int COUNT_DIV   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cp0we,
  input  logic [4:0]            cp0Addr,
  input  logic [31:0]           cp0wData,
  output logic [31:0]           cp0rData,
  input  logic [NUM_HW_INT-1:0] intr,
  input  logic                  excpt_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           pc_i,
  input  logic                  eret,
  output logic                  intimer,
  output logic                  irq_req,
  output logic [31:0]           status,
  output logic [31:0]           cause,
  output logic [31:0]           epc
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_INTMODE = 5'd22;
  localparam logic [4:0] PRESC_LAST   = 5'(COUNT_DIV - 1);

  logic [4:0]            presc_q, presc_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [31:0]           epc_q, epc_d;
  logic                  ie_q, ie_d;
  logic                  exl_q, exl_d;
  logic [7:0]            im_q, im_d;
  logic [4:0]            excode_q, excode_d;
  logic [1:0]            swip_q, swip_d;
  logic [NUM_HW_INT-1:0] edge_ip_q, edge_ip_d;
  logic [NUM_HW_INT-1:0] intmode_q, intmode_d;
  logic [NUM_HW_INT-1:0] sync_prev_q;
  logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];
  logic                  intimer_q, intimer_d;
  logic                  irq_q, irq_d;

  logic [NUM_HW_INT-1:0] sync_w, hwip_w, rise_w, clr_w;
  logic [5:0]            hwip6_w;
  logic                  wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_intmode;
  logic                  match_w;

  assign sync_w = sync_q[SYNC_STAGES-1];
  assign rise_w = sync_w & ~sync_prev_q;

  // Software writes to Status/Cause/EPC lose to a committing exception.
  assign wr_count   = cp0we && (cp0Addr == ADDR_COUNT);
  assign wr_compare = cp0we && (cp0Addr == ADDR_COMPARE);
  assign wr_status  = cp0we && (cp0Addr == ADDR_STATUS) && !excpt_valid;
  assign wr_cause   = cp0we && (cp0Addr == ADDR_CAUSE) && !excpt_valid;
  assign wr_epc     = cp0we && (cp0Addr == ADDR_EPC) && !excpt_valid;
  assign wr_intmode = cp0we && (cp0Addr == ADDR_INTMODE);

  assign match_w = (count_q == compare_q) && (compare_q != 32'd0);

  always_comb begin
    hwip_w = '0;
    for (int i = 0; i < NUM_HW_INT; i++) begin
      if (intmode_q[i]) hwip_w[i] = edge_ip_q[i];
      else              hwip_w[i] = sync_w[i] | ((i == TIMER_LINE) & intimer_q);
    end
  end

  assign hwip6_w = 6'(hwip_w);
  assign clr_w   = wr_cause ? ~cp0wData[10 +: NUM_HW_INT] : '0;

  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    compare_d = compare_q;
    epc_d     = epc_q;
    ie_d      = ie_q;
    exl_d     = exl_q;
    im_d      = im_q;
    excode_d  = excode_q;
    swip_d    = swip_q;
    intmode_d = intmode_q;
    intimer_d = intimer_q | match_w;

    if (wr_count) begin
      count_d = cp0wData;
      presc_d = 5'd0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = 5'd0;
      count_d = count_q + 32'd1;
    end else begin
      presc_d = presc_q + 5'd1;
    end

    if (wr_compare) begin
      compare_d = cp0wData;
      intimer_d = 1'b0;
    end

    if (wr_intmode) intmode_d = cp0wData[NUM_HW_INT-1:0];
    if (wr_cause)   swip_d    = cp0wData[9:8];
    if (wr_epc)     epc_d     = cp0wData;

    if (wr_status) begin
      im_d  = cp0wData[15:8];
      exl_d = cp0wData[1];
      ie_d  = cp0wData[0];
    end

    if (excpt_valid) begin
      epc_d    = pc_i;
      exl_d    = 1'b1;
      excode_d = exc_code;
    end else if (eret) begin
      exl_d = 1'b0;
    end

    // Level-mode lines keep no sticky state, so a later switch to edge starts clean.
    edge_ip_d = intmode_q & ((edge_ip_q & ~clr_w) | rise_w);
    irq_d     = ie_q & ~exl_q & (|({hwip6_w, swip_q} & im_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q     <= '0;
      count_q     <= '0;
      compare_q   <= '0;
      epc_q       <= '0;
      ie_q        <= 1'b0;
      exl_q       <= 1'b0;
      im_q        <= '0;
      excode_q    <= '0;
      swip_q      <= '0;
      edge_ip_q   <= '0;
      intmode_q   <= '0;
      sync_prev_q <= '0;
      intimer_q   <= 1'b0;
      irq_q       <= 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      presc_q     <= presc_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      epc_q       <= epc_d;
      ie_q        <= ie_d;
      exl_q       <= exl_d;
      im_q        <= im_d;
      excode_q    <= excode_d;
      swip_q      <= swip_d;
      edge_ip_q   <= edge_ip_d;
      intmode_q   <= intmode_d;
      sync_prev_q <= sync_w;
      intimer_q   <= intimer_d;
      irq_q       <= irq_d;
      sync_q[0]   <= intr;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign intimer = intimer_q;
  assign irq_req = irq_q;
  assign status  = {16'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause   = {16'd0, hwip6_w, swip_q, 1'b0, excode_q, 2'b00};
  assign epc     = epc_q;

  always_comb begin
    case (cp0Addr)
      ADDR_COUNT:   cp0rData = count_q;
      ADDR_COMPARE: cp0rData = compare_q;
      ADDR_STATUS:  cp0rData = status;
      ADDR_CAUSE:   cp0rData = cause;
      ADDR_EPC:     cp0rData = epc_q;
      ADDR_INTMODE: cp0rData = 32'(intmode_q);
      default:      cp0rData = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: scoreboard bench for cp0_intc; expectations are queued as
// stimulus is driven and drained against captured observations per scenario.
`default_nettype none

module tb_cp0_intc;

  localparam int NUM_HW_INT  = 6;
  localparam int TIMER_LINE  = 5;
  localparam int COUNT_DIV   = 1;
  localparam int SYNC_STAGES = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  cp0we = 1'b0;
  logic [4:0]            cp0Addr = '0;
  logic [31:0]           cp0wData = '0;
  logic [31:0]           cp0rData;
  logic [NUM_HW_INT-1:0] intr = '0;
  logic                  excpt_valid = 1'b0;
  logic [4:0]            exc_code = '0;
  logic [31:0]           pc_i = '0;
  logic                  eret = 1'b0;
  logic                  intimer, irq_req;
  logic [31:0]           status, cause, epc;

  cp0_intc #(
    .NUM_HW_INT (NUM_HW_INT),
    .TIMER_LINE (TIMER_LINE),
    .COUNT_DIV  (COUNT_DIV),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cp0we      (cp0we),
    .cp0Addr    (cp0Addr),
    .cp0wData   (cp0wData),
    .cp0rData   (cp0rData),
    .intr       (intr),
    .excpt_valid(excpt_valid),
    .exc_code   (exc_code),
    .pc_i       (pc_i),
    .eret       (eret),
    .intimer    (intimer),
    .irq_req    (irq_req),
    .status     (status),
    .cause      (cause),
    .epc        (epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] obs_q[$];
  int          nvec = 0;
  int          nerr = 0;

  function automatic void push_exp(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0we    = 1'b1;
    cp0Addr  = a;
    cp0wData = d;
    tick();
    cp0we    = 1'b0;
  endtask

  task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
    cp0Addr = a;
    #1;
    d = cp0rData;
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [31:0] o, rd;
    rst  = 1'b0;
    intr = '1;
    repeat (3) tick();
    push_exp("rst_intimer", 0); obs_q.push_back(32'(intimer));
    push_exp("rst_irq", 0);     obs_q.push_back(32'(irq_req));
    push_exp("rst_status", 0);  obs_q.push_back(status);
    push_exp("rst_cause", 0);   obs_q.push_back(cause);
    push_exp("rst_epc", 0);     obs_q.push_back(epc);
    mfc0(5'd9, rd);
    push_exp("rst_count", 0);   obs_q.push_back(rd);
    rst = 1'b1;
    repeat (6) tick();
    push_exp("post_rst_intimer", 0);  obs_q.push_back(32'(intimer));
    push_exp("post_rst_irq", 0);      obs_q.push_back(32'(irq_req));
    push_exp("post_rst_level_ip", 32'h0000_FC00); obs_q.push_back(cause);
    intr = '0;
    repeat (4) tick();
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      nvec++;
      if (o !== e.val) begin
        $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
        nerr++;
      end
    end
  endtask

  task automatic test_regmap();
    exp_t        e;
    logic [31:0] o, rd;
    mtc0(5'd14, 32'hDEAD_BEEF);
    mtc0(5'd12, 32'hFFFF_FFFF);
    mtc0(5'd22, 32'hFFFF_FFFF);
    mtc0(5'd5,  32'hFFFF_FFFF);
    mfc0(5'd14, rd); push_exp("rd_epc", 32'hDEAD_BEEF);     obs_q.push_back(rd);
    mfc0(5'd12, rd); push_exp("rd_status", 32'h0000_FF03); obs_q.push_back(rd);
    mfc0(5'd22, rd); push_exp("rd_intmode", 32'h0000_003F); obs_q.push_back(rd);
    mfc0(5'd5,  rd); push_exp("rd_unmapped", 32'h0);       obs_q.push_back(rd);
    mtc0(5'd12, 32'h0);
    mtc0(5'd22, 32'h0);
    tick();
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      nvec++;
      if (o !== e.val) begin
        $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
        nerr++;
      end
    end
  endtask

  task automatic test_timer();
    exp_t        e;
    logic [31:0] o, c, prev;
    bit          hit = 1'b0;
    mtc0(5'd9, 32'd10);
    mtc0(5'd11, 32'd20);
    mtc0(5'd12, 32'h0000_8001);
    push_exp("timer_count_before", 32'd20);
    push_exp("timer_count_at_set", 32'd21);
    push_exp("timer_irq_same_cycle", 0);
    prev = '0;
    c    = '0;
    for (int k = 0; k < 100 && !hit; k++) begin
      mfc0(5'd9, c);
      if (intimer) hit = 1'b1;
      else begin
        prev = c;
        tick();
      end
    end
    obs_q.push_back(prev);
    obs_q.push_back(c);
    obs_q.push_back(32'(irq_req));
    tick();
    push_exp("timer_irq_next", 1);   obs_q.push_back(32'(irq_req));
    push_exp("timer_cause_ip15", 1); obs_q.push_back(32'(cause[15]));
    mtc0(5'd11, 32'd40);
    push_exp("timer_clear", 0);      obs_q.push_back(32'(intimer));
    tick();
    push_exp("timer_irq_drop", 0);   obs_q.push_back(32'(irq_req));
    mtc0(5'd11, 32'd0);
    mtc0(5'd12, 32'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      nvec++;
      if (o !== e.val) begin
        $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
        nerr++;
      end
    end
  endtask

  task automatic test_compare_collision();
    exp_t        e;
    logic [31:0] o, c;
    mtc0(5'd11, 32'd50);
    mtc0(5'd9, 32'd45);
    repeat (5) tick();
    mfc0(5'd9, c);
    push_exp("coll_count_match", 32'd50); obs_q.push_back(c);
    mtc0(5'd11, 32'd0);
    push_exp("coll_intimer", 0);          obs_q.push_back(32'(intimer));
    tick();
    push_exp("coll_intimer_later", 0);    obs_q.push_back(32'(intimer));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      nvec++;
      if (o !== e.val) begin
        $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
        nerr++;
      end
    end
  endtask

  task automatic test_edge();
    exp_t        e;
    logic [31:0] o, rd;
    int          n;
    mtc0(5'd22, 32'h1);
    mtc0(5'd12, 32'h0000_0401);
    mfc0(5'd22, rd);
    push_exp("edge_intmode", 32'h1);                  obs_q.push_back(rd);
    push_exp("edge_latency", 32'(SYNC_STAGES + 2));
    intr[0] = 1'b1;
    tick();
    intr[0] = 1'b0;
    n = 1;
    while (!irq_req && n < 20) begin
      tick();
      n++;
    end
    obs_q.push_back(32'(n));
    repeat (3) tick();
    push_exp("edge_sticky_ip", 1);  obs_q.push_back(32'(cause[10]));
    push_exp("edge_sticky_irq", 1); obs_q.push_back(32'(irq_req));
    mtc0(5'd13, 32'h0);
    push_exp("edge_clear_ip", 0);   obs_q.push_back(32'(cause[10]));
    tick();
    push_exp("edge_clear_irq", 0);  obs_q.push_back(32'(irq_req));
    mtc0(5'd22, 32'h0);
    mtc0(5'd12, 32'h0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      nvec++;
      if (o !== e.val) begin
        $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
        nerr++;
      end
    end
  endtask

  task automatic test_level();
    exp_t        e;
    logic [31:0] o;
    int          n_c, n_i, n_d;
    mtc0(5'd12, 32'h0000_1001);
    push_exp("level_ip_latency", 32'(SYNC_STAGES));
    push_exp("level_irq_latency", 32'(SYNC_STAGES + 1));
    intr[2] = 1'b1;
    n_c = 0;
    n_i = 0;
    for (int k = 1; k <= 20 && n_i == 0; k++) begin
      tick();
      if (cause[12] && n_c == 0) n_c = k;
      if (irq_req) n_i = k;
    end
    obs_q.push_back(32'(n_c));
    obs_q.push_back(32'(n_i));
    push_exp("level_ip_fall_latency", 32'(SYNC_STAGES));
    intr[2] = 1'b0;
    n_d = 0;
    for (int k = 1; k <= 20 && n_d == 0; k++) begin
      tick();
      if (!cause[12]) n_d = k;
    end
    obs_q.push_back(32'(n_d));
    repeat (3) tick();
    push_exp("level_not_sticky", 0); obs_q.push_back(32'(cause[12]));
    push_exp("level_irq_gone", 0);   obs_q.push_back(32'(irq_req));
    mtc0(5'd12, 32'h0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      nvec++;
      if (o !== e.val) begin
        $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
        nerr++;
      end
    end
  endtask

  task automatic test_exception();
    exp_t        e;
    logic [31:0] o;
    mtc0(5'd12, 32'h0000_FF01);
    intr[1] = 1'b1;
    repeat (4) tick();
    push_exp("exc_irq_before", 1); obs_q.push_back(32'(irq_req));
    excpt_valid = 1'b1;
    pc_i        = 32'h0000_0040;
    exc_code    = 5'd0;
    tick();
    excpt_valid = 1'b0;
    push_exp("exc_epc", 32'h40);          obs_q.push_back(epc);
    push_exp("exc_status", 32'h0000_FF03); obs_q.push_back(status);
    push_exp("exc_cause", 32'h0000_0800);  obs_q.push_back(cause);
    tick();
    push_exp("exc_irq_masked", 0);         obs_q.push_back(32'(irq_req));
    eret = 1'b1;
    tick();
    eret = 1'b0;
    push_exp("eret_status", 32'h0000_FF01); obs_q.push_back(status);
    push_exp("eret_epc_kept", 32'h40);      obs_q.push_back(epc);
    tick();
    push_exp("eret_irq", 1);                obs_q.push_back(32'(irq_req));
    // Exception, MTC0 Status=0 and ERET all in one cycle.
    excpt_valid = 1'b1;
    pc_i        = 32'h0000_1234;
    exc_code    = 5'h0C;
    eret        = 1'b1;
    cp0we       = 1'b1;
    cp0Addr     = 5'd12;
    cp0wData    = 32'h0;
    tick();
    excpt_valid = 1'b0;
    eret        = 1'b0;
    cp0we       = 1'b0;
    push_exp("coll_status", 32'h0000_FF03); obs_q.push_back(status);
    push_exp("coll_epc", 32'h0000_1234);    obs_q.push_back(epc);
    push_exp("coll_cause", 32'h0000_0830);  obs_q.push_back(cause);
    eret    = 1'b1;
    tick();
    eret    = 1'b0;
    intr[1] = 1'b0;
    mtc0(5'd12, 32'h0);
    repeat (3) tick();
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      nvec++;
      if (o !== e.val) begin
        $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
        nerr++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_regmap();
    test_timer();
    test_compare_collision();
    test_edge();
    test_level();
    test_exception();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running, required finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
